somador_acumulador_pipe: RTL and testbench
==========================================

// Module: somador_acumulador_pipe
// PURPOSE
//  Parametrised successor of the mux+adder+register datapath. Selects one of
//  N_IN operand words, then adds it to entradaA, subtracts it from entradaA, or
//  accumulates it into the output register. Two-stage pipeline with valid
//  tracking, carry/borrow flag, optional saturation and a result counter.
//  Sits between the operand sources and downstream logic that reads saida/out_valid.
// PARAMETERS
//  WIDTH   4  data width of operands and result
//  N_IN    4  number of selectable operand words (>=2)
//  SAT     0  0: wrap-around arithmetic; 1: clamp to 0 / 2**WIDTH-1
//  CNT_W   8  width of the result counter n_ops
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               async reset, active low
//  enable     in   1               1: pipeline advances; 0: every register holds
//  in_valid   in   1               stage-1 capture qualifier
//  op         in   2               00 SOMA, 01 SUB, 10 ACUM, 11 CLR
//  sel        in   $clog2(N_IN)    operand select
//  entradaA   in   WIDTH           first operand (SOMA/SUB)
//  entradas   in   N_IN*WIDTH      operand bank, word k = entradas[k*WIDTH +: WIDTH]
//  saida      out  WIDTH           registered result / accumulator
//  out_valid  out  1               saida updated on the last advancing edge
//  carry      out  1               carry (SOMA/ACUM) or borrow (SUB) of last result
//  n_ops      out  CNT_W           count of results produced, wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (rst=0, async): saida, carry, out_valid, n_ops, all stage-1 regs = 0.
//  Stage 1 (edge with enable=1): latch v1=in_valid, op1=op, a1=entradaA,
//   m1 = entradas word sel (0 if sel>=N_IN).
//  Stage 2 (same edge, from stage-1 regs), only if v1=1:
//   SOMA: r = a1 + m1      SUB: r = a1 - m1
//   ACUM: r = saida + m1   CLR: r = 0, carry = 0
//   Compute at WIDTH+1 bits. carry = bit WIDTH (borrow for SUB).
//   SAT=0: saida = r[WIDTH-1:0]. SAT=1 and carry: saida = all-ones (add) / 0 (SUB).
//   out_valid <= 1; n_ops <= n_ops+1 (wraps).
//  If v1=0 on an advancing edge: saida/carry hold, out_valid <= 0, n_ops holds.
//  Latency: 2 advancing edges from input capture to saida.
//  ACUM reads the current saida at stage 2, so back-to-back ACUMs chain with no
//   bubble (each sees the previous result).
//  enable=0: no register changes; out_valid holds its value; inputs ignored.
//  Reset mid-operation discards in-flight stage-1 data; first valid after
//   release appears 2 advancing edges later.
// TESTING (WIDTH=4, N_IN=4, CNT_W=8)
//  1 SOMA entradaA=3, sel=1, word1=5, in_valid=1 -> 2 edges later saida=8,
//    carry=0, out_valid=1, n_ops=1.
//  2 SOMA 9+9: SAT=0 -> saida=2, carry=1; SAT=1 -> saida=15, carry=1.
//  3 SUB 3-5: SAT=0 -> saida=14, carry=1; SAT=1 -> saida=0, carry=1.
//  4 CLR, then 4 consecutive ACUM with word2=3 -> saida 0,3,6,9,12 on consecutive
//    edges, out_valid=1 throughout; 6th ACUM of 3 -> saida=15->2 wrap with carry=1.
//  5 enable=0 for 3 cycles mid-stream -> saida/out_valid/n_ops frozen; stream
//    resumes with no lost or duplicated result.
//  6 rst=0 asynchronously mid-stream -> all outputs 0 before the next edge; in_valid
//    held low 1 edge -> out_valid=0; n_ops wraps 255->0 after 256 results.

Source files
------------

// File: rtl/somador_acumulador_pipe.sv
// Selectable-operand add / subtract / accumulate datapath with valid, carry and result count.
// Latency: 2 advancing edges from input capture to saida; ACUM chains back-to-back with no bubble.
// Backpressure: enable=0 freezes every register (out_valid holds); there is no ready/stall output.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   enable             1: pipeline advances, 0: all state holds and inputs are ignored
//   in_valid, op, sel  stage-1 qualifier, operation (00 SOMA, 01 SUB, 10 ACUM, 11 CLR), operand select
//   entradaA           first operand for SOMA/SUB
//   entradas           operand bank, word k = entradas[k*WIDTH +: WIDTH]
//   saida, carry       registered result / accumulator and its carry (borrow for SUB)
//   out_valid          saida was updated on the last advancing edge
//   n_ops              number of results produced, wraps at 2**CNT_W
module somador_acumulador_pipe #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 4,
    parameter int SAT   = 0,
    parameter int CNT_W = 8,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic [1:0]              op,
    input  logic [SEL_W-1:0]        sel,
    input  logic [WIDTH-1:0]        entradaA,
    input  logic [N_IN*WIDTH-1:0]   entradas,
    output logic [WIDTH-1:0]        saida,
    output logic                    out_valid,
    output logic                    carry,
    output logic [CNT_W-1:0]        n_ops
);

    typedef enum logic [1:0] {
        OP_SOMA = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACUM = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // Stage-1 capture register.
    typedef struct packed {
        logic             vld;
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] m;
    } s1_t;

    s1_t              s1_q;
    s1_t              s1_d;
    logic [WIDTH-1:0] m_sel;

    // Operand mux. A select value with no matching word (possible when N_IN
    // is not a power of two) yields zero.
    always_comb begin
        m_sel = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                m_sel = entradas[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        s1_d.vld = in_valid;
        s1_d.op  = op_e'(op);
        s1_d.a   = entradaA;
        s1_d.m   = m_sel;
    end

    // Stage-2 arithmetic, one bit wider than the data so the top bit is the
    // carry (or the borrow, for SUB). ACUM uses the live saida so consecutive
    // accumulates see each other's result.
    logic [WIDTH:0]   r_ext;
    logic [WIDTH-1:0] saida_nxt;
    logic             carry_nxt;
    logic             is_sub;

    always_comb begin
        r_ext  = '0;
        is_sub = 1'b0;
        case (s1_q.op)
            OP_SOMA: r_ext = {1'b0, s1_q.a} + {1'b0, s1_q.m};
            OP_SUB: begin
                r_ext  = {1'b0, s1_q.a} - {1'b0, s1_q.m};
                is_sub = 1'b1;
            end
            OP_ACUM: r_ext = {1'b0, saida} + {1'b0, s1_q.m};
            default: r_ext = '0;
        endcase
    end

    always_comb begin
        carry_nxt = r_ext[WIDTH];
        saida_nxt = r_ext[WIDTH-1:0];
        // Saturating mode clamps an overflow to all-ones and an underflow to 0.
        if (SAT != 0 && carry_nxt) begin
            saida_nxt = is_sub ? '0 : '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '0;
            saida     <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            n_ops     <= '0;
        end else if (enable) begin
            s1_q      <= s1_d;
            out_valid <= s1_q.vld;
            if (s1_q.vld) begin
                saida <= saida_nxt;
                carry <= carry_nxt;
                n_ops <= n_ops + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_somador_acumulador_pipe.sv
// Directed bench: two instances (wrap-around and saturating) share one stimulus.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: enable toggled directly by the bench.
module tb_somador_acumulador_pipe;

    localparam int WIDTH = 4;
    localparam int N_IN  = 4;
    localparam int CNT_W = 8;

    localparam logic [1:0] SOMA = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] ACUM = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  in_valid;
    logic [1:0]            op;
    logic [1:0]            sel;
    logic [WIDTH-1:0]      entradaA;
    logic [N_IN*WIDTH-1:0] entradas;

    logic [WIDTH-1:0] saida0, saida1;
    logic             ov0, ov1, carry0, carry1;
    logic [CNT_W-1:0] n0, n1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    somador_acumulador_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .SAT(0), .CNT_W(CNT_W)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .op(op), .sel(sel),
        .entradaA(entradaA), .entradas(entradas),
        .saida(saida0), .out_valid(ov0), .carry(carry0), .n_ops(n0)
    );

    somador_acumulador_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .SAT(1), .CNT_W(CNT_W)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .op(op), .sel(sel),
        .entradaA(entradaA), .entradas(entradas),
        .saida(saida1), .out_valid(ov1), .carry(carry1), .n_ops(n1)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sel;
        logic [3:0]  a;
        logic [15:0] bank;
        logic        vld;
        logic [3:0]  s0;   // expected saida, wrap-around instance
        logic        c0;
        logic [3:0]  s1;   // expected saida, saturating instance
        logic        c1;
        logic        ov;
        logic [7:0]  n;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] s0, input logic c0,
                           input logic [3:0] s1, input logic c1, input logic ov,
                           input logic [7:0] n);
        chk({tag, " saida_wrap"}, 32'(saida0), 32'(s0));
        chk({tag, " carry_wrap"}, 32'(carry0), 32'(c0));
        chk({tag, " saida_sat"},  32'(saida1), 32'(s1));
        chk({tag, " carry_sat"},  32'(carry1), 32'(c1));
        chk({tag, " out_valid"},  32'({ov0, ov1}), 32'({ov, ov}));
        chk({tag, " n_ops_wrap"}, 32'(n0), 32'(n));
        chk({tag, " n_ops_sat"},  32'(n1), 32'(n));
    endtask

    task automatic drive(input logic [1:0] o, input logic [1:0] s, input logic [3:0] a,
                         input logic [15:0] b, input logic v);
        op = o; sel = s; entradaA = a; entradas = b; in_valid = v;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Bank words: w0=2, w1=5, w2=3, w3=7 (word1 = 9 in one entry).
        // Each entry's expectations are the outputs after the edge that
        // captures that entry, i.e. the result of the entry before it.
        tbl[0]  = '{SOMA, 2'd1, 4'd3, 16'h7352, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 8'd0};
        tbl[1]  = '{SOMA, 2'd1, 4'd9, 16'h7392, 1'b1, 4'd8,  1'b0, 4'd8,  1'b0, 1'b1, 8'd1};
        tbl[2]  = '{SUB,  2'd1, 4'd3, 16'h7352, 1'b1, 4'd2,  1'b1, 4'd15, 1'b1, 1'b1, 8'd2};
        tbl[3]  = '{CLR,  2'd1, 4'd3, 16'h7352, 1'b1, 4'd14, 1'b1, 4'd0,  1'b1, 1'b1, 8'd3};
        tbl[4]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 8'd4};
        tbl[5]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd3,  1'b0, 4'd3,  1'b0, 1'b1, 8'd5};
        tbl[6]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd6,  1'b0, 4'd6,  1'b0, 1'b1, 8'd6};
        tbl[7]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd9,  1'b0, 4'd9,  1'b0, 1'b1, 8'd7};
        tbl[8]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0, 1'b1, 8'd8};
        tbl[9]  = '{ACUM, 2'd2, 4'd0, 16'h7352, 1'b1, 4'd15, 1'b0, 4'd15, 1'b0, 1'b1, 8'd9};
        tbl[10] = '{SOMA, 2'd0, 4'd9, 16'h7352, 1'b0, 4'd2,  1'b1, 4'd15, 1'b1, 1'b1, 8'd10};
        tbl[11] = '{SOMA, 2'd0, 4'd9, 16'h7352, 1'b0, 4'd2,  1'b1, 4'd15, 1'b1, 1'b0, 8'd10};
        tbl[12] = '{SOMA, 2'd0, 4'd1, 16'h7352, 1'b1, 4'd2,  1'b1, 4'd15, 1'b1, 1'b0, 8'd10};
        tbl[13] = '{SOMA, 2'd0, 4'd1, 16'h7352, 1'b0, 4'd3,  1'b0, 4'd3,  1'b0, 1'b1, 8'd11};

        rst = 1'b0;
        enable = 1'b1;
        drive(SOMA, 2'd0, 4'd0, 16'h7352, 1'b0);
        #23;
        chk_all("reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        #3;   // now at posedge+1 of the edge at t=25... align to the bench grid
        @(posedge clk);
        #1;

        // Table-driven stream: add, overflow, underflow, clear, accumulate chain.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].bank, tbl[i].vld);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].s0, tbl[i].c0, tbl[i].s1, tbl[i].c1,
                    tbl[i].ov, tbl[i].n);
        end

        // Freeze for 3 cycles with a valid SUB sitting in stage 1.
        drive(SOMA, 2'd3, 4'd4, 16'h7352, 1'b1);
        step();
        chk_all("pre_freeze0", 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 8'd11);
        drive(SUB, 2'd0, 4'd7, 16'h7352, 1'b1);
        step();
        chk_all("pre_freeze1", 4'd11, 1'b0, 4'd11, 1'b0, 1'b1, 8'd12);
        enable = 1'b0;
        drive(CLR, 2'd3, 4'd15, 16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("frozen%0d", i), 4'd11, 1'b0, 4'd11, 1'b0, 1'b1, 8'd12);
        end
        enable = 1'b1;
        drive(SOMA, 2'd0, 4'd0, 16'h7352, 1'b0);
        step();
        chk_all("resume", 4'd5, 1'b0, 4'd5, 1'b0, 1'b1, 8'd13);
        step();
        chk_all("no_dup", 4'd5, 1'b0, 4'd5, 1'b0, 1'b0, 8'd13);

        // Asynchronous reset mid-stream with a valid op in flight.
        drive(SOMA, 2'd3, 4'd15, 16'h7352, 1'b1);
        step();
        drive(SOMA, 2'd0, 4'd1, 16'h7352, 1'b1);
        step();
        chk_all("pre_reset", 4'd6, 1'b1, 4'd15, 1'b1, 1'b1, 8'd14);
        #2 rst = 1'b0;
        #1;
        chk_all("async_reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        #1 rst = 1'b1;
        drive(SOMA, 2'd0, 4'd0, 16'h7352, 1'b0);
        step();
        chk_all("post_reset_idle", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        drive(SOMA, 2'd1, 4'd3, 16'h7352, 1'b1);
        step();
        chk_all("post_reset_lat1", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        drive(SOMA, 2'd0, 4'd0, 16'h7352, 1'b0);
        step();
        chk_all("post_reset_lat2", 4'd8, 1'b0, 4'd8, 1'b0, 1'b1, 8'd1);

        // Result counter wrap: stage 1 holds an invalid entry at loop start,
        // so after k edges the count is k.
        drive(SOMA, 2'd1, 4'd3, 16'h7352, 1'b1);
        for (int i = 0; i < 255; i++) begin
            step();
        end
        chk_all("cnt_255", 4'd8, 1'b0, 4'd8, 1'b0, 1'b1, 8'd255);
        step();
        chk_all("cnt_wrap", 4'd8, 1'b0, 4'd8, 1'b0, 1'b1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
